wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register-file data width (multiple of 8, >=16).
REQ-002 SHALL have parameter REG_AW, default 5, register-file address width.
REQ-003 SHALL have parameter CNT_W, default 32, retire counter width (used only with WB_RETIRE_CNT_EN).
REQ-004 SHALL use one clock and a synchronous, active-high reset (fixed).
REQ-005 SHALL have ports clk_i in 1, rising-edge clock; rst_i in 1, synchronous active-high reset.
REQ-006 SHALL have ports valid_i in 1, incoming instruction valid; stall_i in 1, hold stage; flush_i in 1, kill stage.
REQ-007 SHALL have ports wreg_i in 1, write-enable request; m2reg_i in 1, 1 = select memory data, 0 = ALU result.
REQ-008 SHALL have ports memsize_i in 2, 00 byte / 01 half / 10 word; memsign_i in 1, 1 = sign-extend load; byteoff_i in 2, load byte offset.
REQ-009 SHALL have ports aluresult_i in DATA_W, ALU result; dmemout_i in DATA_W, raw memory word; destination_i in REG_AW, destination register.
REQ-010 SHALL have ports valid_o out 1, stage valid; wreg_o out 1, register-file write strobe; destination_o out REG_AW, write address; datareg_o out DATA_W, write data.
REQ-011 SHALL have port retired_o out CNT_W, retired-instruction count (present only with WB_RETIRE_CNT_EN).

Function
REQ-012 SHALL register all outputs; input-to-output latency exactly 1 clock.
REQ-013 SHALL capture inputs on a rising edge when stall_i=0 and flush_i=0; valid_o <= valid_i.
REQ-014 SHALL hold all output registers unchanged while stall_i=1 and flush_i=0.
REQ-015 SHALL, on flush_i=1, load valid_o=0, wreg_o=0 next cycle; flush wins over stall and over valid_i.
REQ-016 SHALL drive wreg_o = valid_i & wreg_i & (destination_i != 0) at capture; writes to register 0 are always suppressed.
REQ-017 SHALL select datareg_o = aluresult_i when m2reg_i=0, else aligned/extended load data.
REQ-018 SHALL, for byte loads, take dmemout_i[8*byteoff_i +: 8], zero- or sign-extend to DATA_W per memsign_i.
REQ-019 SHALL, for half loads, take dmemout_i[16*byteoff_i[1] +: 16] (byteoff_i[0] ignored), extend per memsign_i.
REQ-020 SHALL, for word loads or memsize_i=11, pass dmemout_i[DATA_W-1:0] unchanged.
REQ-021 SHALL, when valid_i=0 at capture, still update destination_o/datareg_o but force wreg_o=0.
REQ-022 SHALL keep wreg_o, destination_o, datareg_o stable for the full cycle with no combinational path from inputs.

Reset
REQ-023 SHALL, on rst_i=1 at a rising edge, set valid_o=0, wreg_o=0, destination_o=0, datareg_o=0, retired_o=0.
REQ-024 SHALL give rst_i priority over flush_i and stall_i; reset mid-stall discards the held instruction.
REQ-025 SHALL resume normal capture on the first edge with rst_i=0.

Configuration
REQ-026 SHALL, with macro WB_RETIRE_CNT_EN defined, include retired_o, incremented by 1 on each edge where a valid instruction is captured (valid_i=1, stall_i=0, flush_i=0, rst_i=0), wrapping modulo 2^CNT_W.
REQ-027 SHALL, without WB_RETIRE_CNT_EN, omit retired_o and the counter logic entirely; all other behaviour identical.

Verification
REQ-028 SHALL cover ALU path: valid_i=1, wreg_i=1, m2reg_i=0, aluresult_i=0x12345678, destination_i=5 -> next cycle wreg_o=1, destination_o=5, datareg_o=0x12345678.
REQ-029 SHALL cover loads: dmemout_i=0x80FF7F01, byte off 2 signed -> 0xFFFFFFFF; byte off 1 unsigned -> 0x0000007F; half off 2 signed -> 0xFFFF80FF; word -> 0x80FF7F01.
REQ-030 SHALL cover r0 suppression: valid_i=1, wreg_i=1, destination_i=0 -> wreg_o=0, valid_o=1.
REQ-031 SHALL cover stall/flush: capture instr A, stall_i=1 for 3 cycles with new inputs -> outputs hold A; stall_i=1 and flush_i=1 together -> valid_o=0, wreg_o=0.
REQ-032 SHALL cover reset mid-operation: rst_i=1 for 1 cycle while wreg_o=1 -> all outputs 0 next cycle; next valid instruction captured normally.
REQ-033 SHALL cover counter (WB_RETIRE_CNT_EN, CNT_W=4): 17 valid captures, 2 stalled cycles, 1 flushed -> retired_o=1 (wrapped).

Source files
------------

// File: rtl/wb_stage.sv
// wb_stage: register-file write-back stage.
// Selects ALU or aligned/extended load data, suppresses writes to r0,
// and registers the write strobe, address and data with a one-cycle latency.
// Optional feature: define WB_RETIRE_CNT_EN to add the retired_o counter.
module wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              wreg_i,
  input  logic              m2reg_i,
  input  logic [1:0]        memsize_i,
  input  logic              memsign_i,
  input  logic [1:0]        byteoff_i,
  input  logic [DATA_W-1:0] aluresult_i,
  input  logic [DATA_W-1:0] dmemout_i,
  input  logic [REG_AW-1:0] destination_i,
`ifdef WB_RETIRE_CNT_EN
  output logic [CNT_W-1:0]  retired_o,
`endif
  output logic              valid_o,
  output logic              wreg_o,
  output logic [REG_AW-1:0] destination_o,
  output logic [DATA_W-1:0] datareg_o
);

  // Byte/half lanes always come from the low 32 bits; narrower words are
  // zero-padded so every byte offset selects a defined lane.
  logic [31:0] lo32;

  if ((DATA_W % 8) != 0 || DATA_W < 16 || CNT_W < 1) begin : g_bad_param
    $error("wb_stage: DATA_W must be a multiple of 8 and >= 16, CNT_W >= 1");
  end

  if (DATA_W >= 32) begin : g_lo_wide
    assign lo32 = dmemout_i[31:0];
  end else begin : g_lo_narrow
    assign lo32 = {{(32-DATA_W){1'b0}}, dmemout_i};
  end

  function automatic logic signed [DATA_W-1:0] ext8(input logic [7:0] b,
                                                     input logic sgn);
    logic signed [DATA_W-1:0] r;
    if (sgn) r = DATA_W'($signed(b));
    else     r = DATA_W'(b);
    return r;
  endfunction

  function automatic logic signed [DATA_W-1:0] ext16(input logic [15:0] h,
                                                      input logic sgn);
    logic signed [DATA_W-1:0] r;
    if (sgn) r = DATA_W'($signed(h));
    else     r = DATA_W'(h);
    return r;
  endfunction

  // Load alignment: pick the addressed byte/half lane, then extend.
  function automatic logic signed [DATA_W-1:0] load_align(
    input logic [DATA_W-1:0] word,
    input logic [31:0]       low,
    input logic [1:0]        size,
    input logic              sgn,
    input logic [1:0]        off
  );
    logic signed [DATA_W-1:0] r;
    logic [7:0]               b;
    logic [15:0]              h;
    case (off)
      2'd0:    b = low[7:0];
      2'd1:    b = low[15:8];
      2'd2:    b = low[23:16];
      default: b = low[31:24];
    endcase
    h = off[1] ? low[31:16] : low[15:0];
    case (size)
      2'b00:   r = ext8(b, sgn);
      2'b01:   r = ext16(h, sgn);
      default: r = $signed(word);
    endcase
    return r;
  endfunction

  logic signed [DATA_W-1:0] wdata_sel;
  logic                     wen_sel;
  logic                     capture;

  // Stage 0 input side: write-data mux and r0-suppressed write strobe.
  always_comb begin
    wdata_sel = m2reg_i ? load_align(dmemout_i, lo32, memsize_i, memsign_i, byteoff_i)
                        : $signed(aluresult_i);
    wen_sel   = valid_i & wreg_i & (destination_i != '0);
    capture   = ~stall_i & ~flush_i;
  end

  logic                     vld_p0;
  logic                     wreg_p0;
  logic [REG_AW-1:0]        dest_p0;
  logic signed [DATA_W-1:0] data_p0;

  // Output register: reset > flush > stall (hold) > capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p0  <= 1'b0;
      wreg_p0 <= 1'b0;
      dest_p0 <= '0;
      data_p0 <= '0;
    end else if (flush_i) begin
      vld_p0  <= 1'b0;
      wreg_p0 <= 1'b0;
    end else if (capture) begin
      vld_p0  <= valid_i;
      wreg_p0 <= wen_sel;
      dest_p0 <= destination_i;
      data_p0 <= wdata_sel;
    end
  end

  assign valid_o       = vld_p0;
  assign wreg_o        = wreg_p0;
  assign destination_o = dest_p0;
  assign datareg_o     = data_p0;

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] retired_p0;

  // Retire counter: one count per captured valid instruction, wraps naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i)                  retired_p0 <= '0;
    else if (capture & valid_i) retired_p0 <= retired_p0 + 1'b1;
  end

  assign retired_o = retired_p0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed self-checking bench for wb_stage.
// Define WB_RETIRE_CNT_EN for both files to include the retire-counter checks.
module tb_wb_stage;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              valid_i = 1'b0, stall_i = 1'b0, flush_i = 1'b0;
  logic              wreg_i = 1'b0, m2reg_i = 1'b0;
  logic [1:0]        memsize_i = 2'b10;
  logic              memsign_i = 1'b0;
  logic [1:0]        byteoff_i = 2'd0;
  logic [DATA_W-1:0] aluresult_i = '0, dmemout_i = '0;
  logic [REG_AW-1:0] destination_i = '0;
  logic              valid_o, wreg_o;
  logic [REG_AW-1:0] destination_o;
  logic [DATA_W-1:0] datareg_o;
`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0]  retired_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .stall_i(stall_i),
    .flush_i(flush_i), .wreg_i(wreg_i), .m2reg_i(m2reg_i),
    .memsize_i(memsize_i), .memsign_i(memsign_i), .byteoff_i(byteoff_i),
    .aluresult_i(aluresult_i), .dmemout_i(dmemout_i),
    .destination_i(destination_i),
`ifdef WB_RETIRE_CNT_EN
    .retired_o(retired_o),
`endif
    .valid_o(valid_o), .wreg_o(wreg_o), .destination_o(destination_o),
    .datareg_o(datareg_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic instr(input logic v, input logic w, input logic m,
                       input logic [1:0] sz, input logic sg,
                       input logic [1:0] off, input logic [31:0] alu,
                       input logic [4:0] dst);
    valid_i = v; wreg_i = w; m2reg_i = m; memsize_i = sz; memsign_i = sg;
    byteoff_i = off; aluresult_i = alu; destination_i = dst;
  endtask

  initial begin
    // Reset state
    step();
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_wreg",  64'(wreg_o), 64'd0);
    chk("rst_dest",  64'(destination_o), 64'd0);
    chk("rst_data",  64'(datareg_o), 64'd0);
    rst_i = 1'b0;

    // ALU path
    instr(1, 1, 0, 2'b10, 0, 0, 32'h12345678, 5'd5);
    step();
    chk("alu_valid", 64'(valid_o), 64'd1);
    chk("alu_wreg",  64'(wreg_o), 64'd1);
    chk("alu_dest",  64'(destination_o), 64'd5);
    chk("alu_data",  64'(datareg_o), 64'h12345678);

    // Loads from 0x80FF7F01
    dmemout_i = 32'h80FF7F01;
    instr(1, 1, 1, 2'b00, 1, 2'd2, 32'h0, 5'd6); step();
    chk("lb_off2_s", 64'(datareg_o), 64'hFFFFFFFF);
    instr(1, 1, 1, 2'b00, 0, 2'd1, 32'h0, 5'd6); step();
    chk("lbu_off1",  64'(datareg_o), 64'h0000007F);
    instr(1, 1, 1, 2'b01, 1, 2'd2, 32'h0, 5'd6); step();
    chk("lh_off2_s", 64'(datareg_o), 64'hFFFF80FF);
    instr(1, 1, 1, 2'b10, 0, 2'd0, 32'h0, 5'd6); step();
    chk("lw",        64'(datareg_o), 64'h80FF7F01);
    instr(1, 1, 1, 2'b00, 1, 2'd0, 32'h0, 5'd6); step();
    chk("lb_off0_s", 64'(datareg_o), 64'h00000001);
    instr(1, 1, 1, 2'b00, 1, 2'd3, 32'h0, 5'd6); step();
    chk("lb_off3_s", 64'(datareg_o), 64'hFFFFFF80);
    instr(1, 1, 1, 2'b01, 0, 2'd3, 32'h0, 5'd6); step();
    chk("lhu_off3",  64'(datareg_o), 64'h000080FF);
    instr(1, 1, 1, 2'b01, 0, 2'd0, 32'h0, 5'd6); step();
    chk("lhu_off0",  64'(datareg_o), 64'h00007F01);
    instr(1, 1, 1, 2'b11, 1, 2'd1, 32'h0, 5'd6); step();
    chk("size11",    64'(datareg_o), 64'h80FF7F01);

    // r0 suppression
    instr(1, 1, 0, 2'b10, 0, 0, 32'h55, 5'd0); step();
    chk("r0_wreg",  64'(wreg_o), 64'd0);
    chk("r0_valid", 64'(valid_o), 64'd1);

    // Invalid instruction still updates address/data
    instr(0, 1, 0, 2'b10, 0, 0, 32'hAAAA, 5'd7); step();
    chk("inv_valid", 64'(valid_o), 64'd0);
    chk("inv_wreg",  64'(wreg_o), 64'd0);
    chk("inv_dest",  64'(destination_o), 64'd7);
    chk("inv_data",  64'(datareg_o), 64'hAAAA);

    // Capture A then stall 3 cycles with new inputs
    instr(1, 1, 0, 2'b10, 0, 0, 32'hA5A50001, 5'd9); step();
    chk("a_dest", 64'(destination_o), 64'd9);
    stall_i = 1'b1;
    instr(1, 0, 0, 2'b10, 0, 0, 32'h0, 5'd3);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_valid", 64'(valid_o), 64'd1);
      chk("stall_wreg",  64'(wreg_o), 64'd1);
      chk("stall_dest",  64'(destination_o), 64'd9);
      chk("stall_data",  64'(datareg_o), 64'hA5A50001);
    end

    // Stall and flush together
    flush_i = 1'b1; step();
    chk("sf_valid", 64'(valid_o), 64'd0);
    chk("sf_wreg",  64'(wreg_o), 64'd0);
    stall_i = 1'b0; flush_i = 1'b0;

    // Capture B, then reset mid-operation
    instr(1, 1, 0, 2'b10, 0, 0, 32'h0BAD, 5'd12); step();
    chk("b_wreg", 64'(wreg_o), 64'd1);
    chk("b_data", 64'(datareg_o), 64'h0BAD);
    rst_i = 1'b1;
    instr(1, 1, 0, 2'b10, 0, 0, 32'h1357, 5'd13); step();
    chk("mrst_valid", 64'(valid_o), 64'd0);
    chk("mrst_wreg",  64'(wreg_o), 64'd0);
    chk("mrst_dest",  64'(destination_o), 64'd0);
    chk("mrst_data",  64'(datareg_o), 64'd0);
    rst_i = 1'b0; step();
    chk("post_wreg", 64'(wreg_o), 64'd1);
    chk("post_dest", 64'(destination_o), 64'd13);
    chk("post_data", 64'(datareg_o), 64'h1357);

    // Flush alone beats valid_i
    flush_i = 1'b1; step();
    chk("fl_valid", 64'(valid_o), 64'd0);
    chk("fl_wreg",  64'(wreg_o), 64'd0);
    flush_i = 1'b0;

`ifdef WB_RETIRE_CNT_EN
    // Retire counter: 17 captures, 2 stalled, 1 flushed -> 17 mod 16
    rst_i = 1'b1; step();
    chk("cnt_rst", 64'(retired_o), 64'd0);
    rst_i = 1'b0;
    instr(1, 1, 0, 2'b10, 0, 0, 32'h1, 5'd1);
    for (int i = 0; i < 15; i++) step();
    chk("cnt_15", 64'(retired_o), 64'd15);
    stall_i = 1'b1; step(); step(); stall_i = 1'b0;
    flush_i = 1'b1; step(); flush_i = 1'b0;
    chk("cnt_hold", 64'(retired_o), 64'd15);
    step(); step();
    chk("cnt_wrap", 64'(retired_o), 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
